fpga_top: RTL and testbench
===========================

Name: fpga_top

Overview:
- Board-level top for the DE1-SoC-style FPGA target.
- Takes the 50 MHz board clock, push-buttons and slide switches.
- Generates a core clock-enable (free-run, divided or single-step) and advances a 32-bit step counter that stands in for the core's retired-cycle count.
- Shows the count on the six 7-segment displays and LEDs; build-time options VGA/audio/PS2 are excluded from this block.

Parameters:
- DIV_FAST, 50_000, clock-enable divisor for mode 01 (1 kHz at 50 MHz).
- DIV_SLOW, 50_000_000, clock-enable divisor for mode 10 (1 Hz).

Ports:
- CLOCK_50  in  1  single system clock, 50 MHz; all logic on its rising edge.
- KEY  in  4  push-buttons, active-low (pressed = 0). Button assignments:
  - KEY[0]: reset request; internal reset = ~KEY[0].
  - KEY[1]: step.
  - KEY[2]: clear.
  - KEY[3]: pause toggle.
- SW  in  8  slide switches. Switch assignments:
  - SW[1:0]: clock mode.
  - SW[2]: display page select.
  - SW[7:3]: reserved, ignored.
- LEDR  out  10  status LEDs, active-high.
- HEX0..HEX5  out  7 each  seven-segment digits, active-low, bit order {g,f,e,d,c,b,a}; HEX0 is the least-significant digit.

Behaviour:
- One clock; reset is asynchronous and active-high.
  - Internal reset = ~KEY[0].
  - Assertion is asynchronous.
  - Deassertion is synchronised through 2 flops.
  - All registers also hold their reset values at FPGA configuration.
- Reset values:
  - count = 0, paused = 0, divider counter = 0.
  - Key synchronisers = 1 (released).
  - LEDR[9] = 1 while reset is active; HEX all show "0" (7'b1000000).
- Key inputs KEY[3:1]:
  - Each passes through a 2-flop synchroniser plus a history flop.
  - press = history & ~sync (one-cycle pulse per 1→0 transition).
  - No debounce filter: minimum press width is 2 clock cycles.
  - A held key produces exactly one pulse.
- Clock enable ce (one-cycle pulse), by SW[1:0]:
  - 00: ce = 1 every cycle unless paused.
  - 01: ce pulses once every DIV_FAST cycles unless paused.
  - 10: ce pulses once every DIV_SLOW cycles unless paused.
  - 11: single-step; ce = press[1], and pause is ignored.
- Divider counter:
  - Resets to 0 when SW[1:0] changes.
  - Wraps at divisor-1.
- KEY[3] press toggles paused; ignored in mode 11.
- Step counter count[31:0]:
  - Priority: clear (press[2]) > ce increment > hold.
  - Simultaneous KEY[1]+KEY[2] press in mode 11 → count = 0, no increment.
  - Wraps 0xFFFFFFFF → 0.
- Latency: a KEY[1] falling edge changes count at the 3rd rising CLOCK_50 edge after KEY is first sampled low.
- Display:
  - SW[2] = 0: HEX5..HEX0 show count[23:0].
  - SW[2] = 1: HEX5..HEX0 show {16'h0, count[31:24]}.
  - HEX outputs are combinational from count and SW[2].
  - Standard hex glyphs 0–F:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- LEDR assignments:
  - LEDR[7:0] = count[7:0].
  - LEDR[8] = (SW[1:0] == 11).
  - LEDR[9] = reset active.
- Key presses during reset are discarded; the synchronisers are held at 1.

Test Plan:
- Reset: KEY=1110 for 200 ns, SW=00000011 → count 0, all HEX = 1000000, LEDR = 10'b1100000000; after KEY=1111, LEDR[9] = 0 within 2 cycles.
- Single step: SW=00000011, after reset pulse KEY=1101 for 40 ns → count = 1 at 3rd edge, HEX0 = 1111001; hold key 1 µs → still 1.
- Simultaneous step+clear: count = 5, KEY=1001 for 40 ns → count = 0, never 6.
- Free run: SW=00000000 after reset → count increments by 1 every cycle; after 100 cycles LEDR[7:0] = 100; one KEY[3] press freezes the count, a second press resumes it.
- Divided mode: SW=00000001, DIV_FAST overridden to 4 → count +1 every 4 cycles; switching to 00 restarts the divider.
- Wrap/page: count forced near 0xFFFFFFFF in free run → wraps to 0; SW[2]=1 with count=0xAB000000 → HEX1 = 0001000 (A), HEX0 = 0000011 (b), HEX5..HEX2 = 1000000.

Source files
------------

// File: rtl/fpga_top.sv
// Board top: reset bridge, key edge detect, clock-enable generator, 32-bit step counter, 7-seg/LED view.
// Latency: a KEY[1] press moves count on the 3rd CLOCK_50 edge after the key is first sampled low.
// Backpressure: none; free-running board I/O with no flow control.
module fpga_top #(
    parameter int DIV_FAST = 50_000,
    parameter int DIV_SLOW = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [7:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [31:0] FAST_LAST = 32'(DIV_FAST - 1);
    localparam logic [31:0] SLOW_LAST = 32'(DIV_SLOW - 1);

    logic        rst_req;
    logic [1:0]  rst_pipe;
    logic        rst;
    logic [2:0]  key_s1;
    logic [2:0]  key_s2;
    logic [2:0]  key_hist;
    logic [2:0]  press;      // [0] step, [1] clear, [2] pause toggle
    logic [1:0]  mode;
    logic [1:0]  mode_q;
    logic        mode_chg;
    logic [31:0] div_cnt;
    logic [31:0] div_nxt;
    logic [31:0] div_last;
    logic        div_hit;
    logic        ce;
    logic        paused;
    logic        paused_nxt;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic [23:0] disp;
    logic        unused_sw;

    assign rst_req   = ~KEY[0];
    assign rst       = rst_pipe[1];
    assign mode      = SW[1:0];
    assign mode_chg  = (mode != mode_q);
    assign press     = key_hist & ~key_s2;
    assign unused_sw = ^SW[7:3];

    // Reset bridge: assert immediately, release only after two clean clock edges.
    always_ff @(posedge CLOCK_50 or posedge rst_req) begin
        if (rst_req) rst_pipe <= 2'b11;
        else         rst_pipe <= {rst_pipe[0], 1'b0};
    end

    // Key synchronisers plus one history stage; held released during reset so presses are dropped.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_s1   <= 3'b111;
            key_s2   <= 3'b111;
            key_hist <= 3'b111;
        end else begin
            key_s1   <= KEY[3:1];
            key_s2   <= key_s1;
            key_hist <= key_s2;
        end
    end

    // Last cycle's mode; left unreset so a mode held across reset is not mistaken for a change.
    always_ff @(posedge CLOCK_50) begin
        mode_q <= mode;
    end

    // Clock-enable selection, divider advance and counter/pause next-state.
    always_comb begin
        div_last   = (mode == 2'b10) ? SLOW_LAST : FAST_LAST;
        div_hit    = (div_cnt == div_last);
        div_nxt    = div_cnt;
        ce         = 1'b0;
        paused_nxt = paused;
        count_nxt  = count;
        case (mode)
            2'b00: begin
                ce      = ~paused;
                div_nxt = '0;
            end
            2'b11: begin
                ce      = press[0];
                div_nxt = '0;
            end
            default: begin
                if (mode_chg) begin
                    div_nxt = '0;
                end else if (!paused) begin
                    ce      = div_hit;
                    div_nxt = div_hit ? 32'd0 : div_cnt + 32'd1;
                end
            end
        endcase
        if (press[2] && (mode != 2'b11)) paused_nxt = ~paused;
        if (press[1])  count_nxt = '0;
        else if (ce)   count_nxt = count + 32'd1;
    end

    // Core state; count is rewritten every cycle even when holding.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            count   <= '0;
            paused  <= 1'b0;
            div_cnt <= '0;
        end else begin
            count   <= count_nxt;
            paused  <= paused_nxt;
            div_cnt <= div_nxt;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Page 1 shows the top byte so the full 32-bit count is reachable on six digits.
    assign disp = SW[2] ? {16'h0, count[31:24]} : count[23:0];
    assign HEX0 = seg7(disp[3:0]);
    assign HEX1 = seg7(disp[7:4]);
    assign HEX2 = seg7(disp[11:8]);
    assign HEX3 = seg7(disp[15:12]);
    assign HEX4 = seg7(disp[19:16]);
    assign HEX5 = seg7(disp[23:20]);
    assign LEDR = {rst, (mode == 2'b11), count[7:0]};

endmodule

// File: tb/tb_fpga_top.sv
// Bench for fpga_top: directed scenarios plus random key/switch activity against a behavioural model.
// Latency: model tracks key samples per edge; outputs compared every falling edge.
// Backpressure: none.
module tb_fpga_top;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [7:0] sw;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit saw6     = 1'b0;

    logic [6:0] glyph [16];

    // Model state
    logic [31:0] m_count;
    bit          m_paused;
    int          m_elapsed;     // unpaused cycles since entering the current divided mode
    int          m_rst_left;    // edges until the internal reset drops
    logic [2:0]  m_hist [3];    // KEY[3:1] samples, [0] newest
    logic [1:0]  m_prev_mode;

    always #10 clk = ~clk;

    fpga_top #(.DIV_FAST(4), .DIV_SLOW(8)) dut (
        .CLOCK_50(clk),
        .KEY(key),
        .SW(sw),
        .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] exp_hex(input logic [31:0] c, input logic page);
        logic [23:0] d;
        logic [41:0] r;
        d = page ? {16'h0, c[31:24]} : c[23:0];
        for (int i = 0; i < 6; i++) r[i*7 +: 7] = glyph[d[i*4 +: 4]];
        return r;
    endfunction

    // Behavioural model, advanced on every rising edge from the inputs present before the edge.
    always @(posedge clk) begin : model
        logic [2:0] pr;
        bit         ce;
        int         div;
        if (!key[0] || m_rst_left > 0) begin
            m_count   = 0;
            m_paused  = 0;
            m_elapsed = 0;
            for (int i = 0; i < 3; i++) m_hist[i] = 3'b111;
            if (!key[0]) m_rst_left = 2;
            else         m_rst_left = m_rst_left - 1;
        end else begin
            // a press is seen once a key sampled high is followed by a low sample
            pr = m_hist[2] & ~m_hist[1];
            ce = 0;
            case (sw[1:0])
                2'd0: begin ce = !m_paused; m_elapsed = 0; end
                2'd3: begin ce = pr[0];     m_elapsed = 0; end
                default: begin
                    div = (sw[1:0] == 2'd2) ? 8 : 4;
                    if (sw[1:0] != m_prev_mode) m_elapsed = 0;
                    else if (!m_paused) begin
                        m_elapsed++;
                        ce = (m_elapsed % div == 0);
                    end
                end
            endcase
            if (pr[2] && sw[1:0] != 2'd3) m_paused = !m_paused;
            if (pr[1])   m_count = 0;
            else if (ce) m_count = m_count + 1;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = key[3:1];
        end
        m_prev_mode = sw[1:0];
    end

    // Continuous comparison of all outputs, away from the active edge.
    always @(negedge clk) begin : compare
        bit          ra;
        logic [31:0] ec;
        if (chk_en) begin
            ra = !key[0] || (m_rst_left > 0);
            ec = ra ? 32'd0 : m_count;
            check("ledr", 64'(LEDR), 64'({ra, sw[1:0] == 2'd3, ec[7:0]}));
            check("hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(exp_hex(ec, sw[2])));
        end
    end

    task automatic pulse(input logic [3:0] low_mask);
        @(posedge clk); #2 key = key & ~low_mask;
        @(posedge clk);
        @(posedge clk); #2 key = key | low_mask;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset(input logic [7:0] s, input int n);
        @(posedge clk); #2 key = 4'b1110; sw = s;
        repeat (n) @(posedge clk);
        #2 key = 4'b1111;
    endtask

    initial begin
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        key = 4'b1110;
        sw  = 8'b0000_0011;
        m_count = 0; m_paused = 0; m_elapsed = 0; m_rst_left = 2;
        for (int i = 0; i < 3; i++) m_hist[i] = 3'b111;
        m_prev_mode = 2'b11;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset state
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rst_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{7'b1000000}}));
        check("rst_ledr", 64'(LEDR), 64'(10'b1100000000));
        @(posedge clk); #2 key = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_release", 64'(LEDR[9]), 64'(0));

        // Single step with latency, then a long hold
        @(posedge clk); #2 key = 4'b1101;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("step_before_3rd", 64'(HEX0), 64'(7'b1000000));
        @(posedge clk);
        @(negedge clk);
        check("step_3rd_edge", 64'(HEX0), 64'(7'b1111001));
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("step_hold", 64'(HEX0), 64'(7'b1111001));
        @(posedge clk); #2 key = 4'b1111;
        repeat (4) pulse(4'b0010);
        @(negedge clk);
        check("step_five", 64'(HEX0), 64'(7'b0010010));

        // Simultaneous step + clear
        @(posedge clk); #2 key = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (HEX0 == 7'b0000010) saw6 = 1'b1;
            if (i == 1) begin
                @(posedge clk); #2 key = 4'b1111;
            end
        end
        check("clear_wins", 64'(HEX0), 64'(7'b1000000));
        check("never_six", 64'(saw6), 64'(0));

        // Free run
        do_reset(8'b0000_0000, 5);
        repeat (102) @(posedge clk);
        @(negedge clk);
        check("free_100", 64'(LEDR[7:0]), 64'(100));
        pulse(4'b1000);
        repeat (10) @(posedge clk);
        pulse(4'b1000);
        repeat (10) @(posedge clk);

        // Divided mode
        do_reset(8'b0000_0001, 5);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("div_fast_3", 64'(LEDR[7:0]), 64'(3));
        repeat (7) @(posedge clk);
        #2 sw = 8'b0000_0000;
        repeat (5) @(posedge clk);
        #2 sw = 8'b0000_0001;
        repeat (20) @(posedge clk);
        #2 sw = 8'b0000_0010;
        repeat (30) @(posedge clk);
        #2 sw = 8'b0000_0000;

        // Wrap through 0xFFFFFFFF on the upper page
        pulse(4'b1000);
        @(posedge clk); #2 force dut.count = 32'hFFFF_FFF0; m_count = 32'hFFFF_FFF0; sw = 8'b0000_0100;
        @(negedge clk);
        check("wrap_pre", 64'({HEX1, HEX0}), 64'({7'b0001110, 7'b0001110}));
        @(posedge clk); #2 release dut.count;
        pulse(4'b1000);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("wrap_post", 64'({HEX1, HEX0}), 64'({2{7'b1000000}}));

        // Page select with count = 0xAB000000
        pulse(4'b1000);
        @(posedge clk); #2 force dut.count = 32'hAB00_0000; m_count = 32'hAB00_0000;
        @(negedge clk);
        check("page_hi", 64'({HEX1, HEX0}), 64'({7'b0001000, 7'b0000011}));
        check("page_zero", 64'({HEX5, HEX4, HEX3, HEX2}), 64'({4{7'b1000000}}));
        @(posedge clk); #2 release dut.count;
        @(posedge clk); #2 sw = 8'b0000_0000;
        @(negedge clk);
        check("page_lo", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{7'b1000000}}));
        pulse(4'b1000);

        // Random activity
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #2;
            if ($urandom_range(63) == 0) sw[1:0] = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) sw[2] = ~sw[2];
            if ($urandom_range(15) == 0) sw[7:3] = 5'($urandom);
            for (int k = 1; k < 4; k++) if ($urandom_range(5) == 0) key[k] = ~key[k];
            if (key[0] == 1'b0) begin
                if ($urandom_range(3) == 0) key[0] = 1'b1;
            end else if ($urandom_range(499) == 0) begin
                key[0] = 1'b0;
            end
        end
        @(posedge clk); #2 key = 4'b1111;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
